// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Round-robin two-port sequencer that loads B then A onto the ALU
//            bus, holds the unit code for SETTLE cycles and returns y / L.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  op0,
    input  logic [3:0]  op1,
    input  logic [2:0]  roll0,
    input  logic [2:0]  roll1,
    input  logic        lin0,
    input  logic        lin1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [15:0] result,
    output logic        l_result,
    output logic        busy,
    output logic [15:0] ibus_out,
    output logic        ibus_drive,
    output logic        w_a,
    output logic        w_b,
    output logic [3:0]  runit,
    output logic [2:0]  rollop,
    output logic        l_out,
    input  logic [15:0] y,
    input  logic        alu_l_toggle
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_SETUP_B  = 3'd1;
    localparam logic [2:0] c_STROBE_B = 3'd2;
    localparam logic [2:0] c_SETUP_A  = 3'd3;
    localparam logic [2:0] c_STROBE_A = 3'd4;
    localparam logic [2:0] c_EXEC     = 3'd5;
    localparam logic [2:0] c_DONE     = 3'd6;

    localparam logic [3:0] c_LAST     = 4'(SETTLE - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;
    logic        win_q, win_d;
    logic [3:0]  op_q, op_d;
    logic [2:0]  roll_q, roll_d;
    logic        lin_q, lin_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] result_q, result_d;
    logic        lres_q, lres_d;
    logic        w_pick;

    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [15:0] ibus_out_q, ibus_out_d;
    logic        ibus_drive_q, ibus_drive_d;
    logic        w_a_q, w_a_d;
    logic        w_b_q, w_b_d;
    logic [3:0]  runit_q, runit_d;
    logic [2:0]  rollop_q, rollop_d;
    logic        l_out_q, l_out_d;

    // State, latched operation and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= c_IDLE;
            cnt_q        <= 4'd0;
            ptr_q        <= 1'b0;
            win_q        <= 1'b0;
            op_q         <= 4'd0;
            roll_q       <= 3'd0;
            lin_q        <= 1'b0;
            a_q          <= 16'd0;
            b_q          <= 16'd0;
            result_q     <= 16'd0;
            lres_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            ibus_out_q   <= 16'd0;
            ibus_drive_q <= 1'b0;
            w_a_q        <= 1'b1;
            w_b_q        <= 1'b1;
            runit_q      <= 4'd0;
            rollop_q     <= 3'd0;
            l_out_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            op_q         <= op_d;
            roll_q       <= roll_d;
            lin_q        <= lin_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            lres_q       <= lres_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            ibus_out_q   <= ibus_out_d;
            ibus_drive_q <= ibus_drive_d;
            w_a_q        <= w_a_d;
            w_b_q        <= w_b_d;
            runit_q      <= runit_d;
            rollop_q     <= rollop_d;
            l_out_q      <= l_out_d;
        end
    end

    // Next state: arbitration, operand latch, settle count and result capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        op_d     = op_q;
        roll_d   = roll_q;
        lin_d    = lin_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        lres_d   = lres_q;
        // ptr_q names the requester that wins a tie
        w_pick   = (req0 && req1) ? ptr_q : req1;

        case (state_q)
            c_IDLE: begin
                if (req0 || req1) begin
                    win_d  = w_pick;
                    ptr_d  = ~w_pick;
                    op_d   = w_pick ? op1   : op0;
                    roll_d = w_pick ? roll1 : roll0;
                    lin_d  = w_pick ? lin1  : lin0;
                    a_d    = w_pick ? a1    : a0;
                    b_d    = w_pick ? b1    : b0;
                    cnt_d  = 4'd0;
                    if (op_d[3]) begin
                        state_d = c_SETUP_B;
                    end else begin
                        state_d  = c_DONE;
                        result_d = 16'd0;
                        lres_d   = 1'b0;
                    end
                end
            end
            c_SETUP_B:  state_d = c_STROBE_B;
            c_STROBE_B: state_d = c_SETUP_A;
            c_SETUP_A:  state_d = c_STROBE_A;
            c_STROBE_A: begin
                state_d = c_EXEC;
                cnt_d   = 4'd0;
            end
            c_EXEC: begin
                if (cnt_q == c_LAST) begin
                    state_d  = c_DONE;
                    result_d = y;
                    lres_d   = alu_l_toggle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        ibus_drive_d = 1'b0;
        ibus_out_d   = 16'd0;
        w_a_d        = 1'b1;
        w_b_d        = 1'b1;
        runit_d      = 4'd0;
        rollop_d     = 3'd0;
        l_out_d      = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err_d        = 1'b0;
        busy_d       = (state_d != c_IDLE);

        case (state_d)
            c_SETUP_B, c_STROBE_B: begin
                ibus_drive_d = 1'b1;
                ibus_out_d   = b_d;
                w_b_d        = (state_d != c_STROBE_B);
            end
            c_SETUP_A, c_STROBE_A: begin
                ibus_drive_d = 1'b1;
                ibus_out_d   = a_d;
                w_a_d        = (state_d != c_STROBE_A);
            end
            c_EXEC: begin
                runit_d  = op_d;
                rollop_d = roll_d;
                l_out_d  = lin_d;
            end
            c_DONE: begin
                done0_d = ~win_d;
                done1_d = win_d;
                err_d   = ~op_d[3];
            end
            default: ;
        endcase
    end

    assign done0      = done0_q;
    assign done1      = done1_q;
    assign err        = err_q;
    assign result     = result_q;
    assign l_result   = lres_q;
    assign busy       = busy_q;
    assign ibus_out   = ibus_out_q;
    assign ibus_drive = ibus_drive_q;
    assign w_a        = w_a_q;
    assign w_b        = w_b_q;
    assign runit      = runit_q;
    assign rollop     = rollop_q;
    assign l_out      = l_out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Scoreboarded random and directed bench for alu_sequencer with a
//            behavioural ALU attached to the operand bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  op0 = 4'd0, op1 = 4'd0;
    logic [2:0]  roll0 = 3'd0, roll1 = 3'd0;
    logic        lin0 = 1'b0, lin1 = 1'b0;
    logic [15:0] a0 = 16'd0, b0 = 16'd0, a1 = 16'd0, b1 = 16'd0;
    logic        done0, done1, err, l_result, busy, ibus_drive, w_a, w_b, l_out;
    logic [15:0] result, ibus_out, y;
    logic [3:0]  runit;
    logic [2:0]  rollop;
    logic        alu_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [15:0] areg = 16'd0, breg = 16'd0;

    alu_sequencer #(.SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .roll0(roll0), .roll1(roll1), .lin0(lin0), .lin1(lin1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .err(err), .result(result),
        .l_result(l_result), .busy(busy), .ibus_out(ibus_out),
        .ibus_drive(ibus_drive), .w_a(w_a), .w_b(w_b), .runit(runit),
        .rollop(rollop), .l_out(l_out), .y(y), .alu_l_toggle(alu_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench ALU: ADD yields sum/carry; other units an asymmetric mix of all inputs
    function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [2:0] roll,
                                          input logic lin, input logic [15:0] a, input logic [15:0] b);
        if (op == 4'b1000) return {1'b0, a} + {1'b0, b};
        return {lin ^ roll[0], a - b + 16'({op, roll, lin})};
    endfunction

    function automatic logic [17:0] expect_f(input logic [3:0] op, input logic [2:0] roll,
                                             input logic lin, input logic [15:0] a, input logic [15:0] b);
        if (!op[3]) return 18'h20000;
        return {1'b0, alu_f(op, roll, lin, a, b)};
    endfunction

    assign {alu_l, y} = alu_f(runit, rollop, l_out, areg, breg);

    always @(negedge clk) begin
        if (!w_a) areg <= ibus_out;
        if (!w_b) breg <= ibus_out;
    end

    // Monitor: pops expected results on done, and polices strobe shape
    logic prev_wa_low = 1'b0, prev_wb_low = 1'b0;
    always @(negedge clk) begin
        logic [17:0] e;
        if (reset) begin
            if (done0 && done1) begin
                checks++; errors++;
                $display("FAIL both_done: done0=%b done1=%b, want only one", done0, done1);
            end
            if (done0 || done1) begin
                checks++;
                if ((done1 ? q1.size() : q0.size()) == 0) begin
                    errors++;
                    $display("FAIL unexpected_done%0d: got done with nothing outstanding", done1);
                end else begin
                    e = done1 ? q1.pop_front() : q0.pop_front();
                    if ({err, l_result, result} !== e) begin
                        errors++;
                        $display("FAIL done%0d_result: got err=%b l=%b y=%h, want err=%b l=%b y=%h",
                                 done1, err, l_result, result, e[17], e[16], e[15:0]);
                    end
                end
            end
            if (!w_a || !w_b) begin
                checks++;
                if ((!w_a && prev_wa_low) || (!w_b && prev_wb_low) || !ibus_drive || (!w_a && !w_b)) begin
                    errors++;
                    $display("FAIL strobe_shape: w_a=%b w_b=%b drive=%b prev_a=%b prev_b=%b, want single 1-cycle strobe with bus driven",
                             w_a, w_b, ibus_drive, prev_wa_low, prev_wb_low);
                end
            end
        end
        prev_wa_low <= reset && !w_a;
        prev_wb_low <= reset && !w_b;
    end

    task automatic drive(input int i, input logic [3:0] op, input logic [2:0] roll,
                         input logic lin, input logic [15:0] a, input logic [15:0] b);
        if (i == 0) begin
            op0 = op; roll0 = roll; lin0 = lin; a0 = a; b0 = b; req0 = 1'b1;
            q0.push_back(expect_f(op, roll, lin, a, b));
        end else begin
            op1 = op; roll1 = roll; lin1 = lin; a1 = a; b1 = b; req1 = 1'b1;
            q1.push_back(expect_f(op, roll, lin, a, b));
        end
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(i == 0 ? done0 : done1) && n < 100);
        if (!(i == 0 ? done0 : done1)) begin
            checks++; errors++;
            $display("FAIL timeout_done%0d: got no done in %0d cycles, want done", i, n);
        end
        if (i == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL timeout_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [2:0] roll,
                         input logic lin, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        drive(i, op, roll, lin, a, b);
        wait_done(i);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    logic [15:0] bus_exp   [7] = '{16'h4321, 16'h4321, 16'h1234, 16'h1234, 16'h0, 16'h0, 16'h0};
    logic        drive_exp [7] = '{1, 1, 1, 1, 0, 0, 0};
    logic        wb_exp    [7] = '{1, 0, 1, 1, 1, 1, 1};
    logic        wa_exp    [7] = '{1, 1, 1, 0, 1, 1, 1};
    logic [3:0]  runit_exp [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0};
    logic        done_exp  [7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        int cnt;
        bit seen;
        int last_cyc;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_strobes_bus", {w_a, w_b, ibus_drive, ibus_out}, {1'b1, 1'b1, 1'b0, 16'h0});
        chk("reset_ctrl", {runit, rollop, l_out, done0, done1, err, busy}, 64'h0);
        chk("reset_result", {result, l_result}, 64'h0);
        reset = 1'b1;

        // Single ADD with per-cycle trace; operands scrambled after grant
        wait_idle();
        drive(0, 4'b1000, 3'd0, 1'b0, 16'h1234, 16'h4321);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j == 1) begin a0 = 16'hdead; b0 = 16'hbeef; end
            chk($sformatf("add_trace_%0d", j),
                {ibus_drive, ibus_drive ? ibus_out : 16'h0, w_b, w_a, runit, done0},
                {drive_exp[j], bus_exp[j], wb_exp[j], wa_exp[j], runit_exp[j], done_exp[j]});
        end
        chk("add_result", {result, l_result}, {16'h5555, 1'b0});
        req0 = 1'b0;

        // Carry
        issue(0, 4'b1000, 3'd0, 1'b0, 16'hffff, 16'h0001);
        chk("carry_result", {result, l_result}, {16'h0000, 1'b1});

        // Illegal op: done/err the cycle after grant, no strobes, no runit
        wait_idle();
        drive(1, 4'b0011, 3'd5, 1'b1, 16'h1111, 16'h2222);
        @(negedge clk);
        chk("illegal_timing", {done1, err, w_a, w_b, runit, result}, {1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 16'h0});
        req1 = 1'b0;

        // ROLL pass-through, request dropped mid-operation
        wait_idle();
        drive(0, 4'b1100, 3'b010, 1'b1, 16'h0f0f, 16'h00ff);
        cnt = 0;
        seen = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j == 2) req0 = 1'b0;
            if (runit == 4'b1100 && rollop == 3'b010 && l_out) cnt++;
            if (done0) seen = 1'b1;
        end
        chk("roll_hold_cycles", 64'(cnt), 64'(SETTLE));
        chk("roll_done_after_drop", {63'h0, seen}, 64'h1);

        // Reset during EXEC aborts
        wait_idle();
        drive(0, 4'b1000, 3'd0, 1'b0, 16'h0100, 16'h0200);
        cnt = 0;
        while (runit == 4'h0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("reached_exec", {60'h0, runit}, 64'h8);
        reset = 1'b0;
        #1;
        chk("async_reset_abort", {runit, busy, ibus_drive, done0}, 64'h0);
        void'(q0.pop_back());
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issue(0, 4'b1000, 3'd0, 1'b0, 16'd3, 16'd4);
        chk("post_reset_add", {48'h0, result}, 64'd7);

        // Contention from reset release: order 0,1,0,1 spaced 6+SETTLE cycles
        wait_idle();
        reset = 1'b0;
        drive(0, 4'b1000, 3'd0, 1'b0, 16'($urandom), 16'($urandom));
        drive(1, 4'b1001, 3'd3, 1'b0, 16'($urandom), 16'($urandom));
        @(negedge clk);
        reset = 1'b1;
        last_cyc = 0;
        for (int n = 0; n < 4; n++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!(done0 || done1) && cnt < 50);
            chk($sformatf("contend_order_%0d", n), {62'h0, done1, done0}, (n % 2) ? 64'h2 : 64'h1);
            if (n > 0) chk($sformatf("contend_gap_%0d", n), 64'(cyc - last_cyc), 64'(6 + SETTLE));
            last_cyc = cyc;
            if (n == 0) drive(0, 4'b1010, 3'd1, 1'b1, 16'($urandom), 16'($urandom));
            if (n == 1) drive(1, 4'b1000, 3'd0, 1'b0, 16'($urandom), 16'($urandom));
            if (n == 2) req0 = 1'b0;
            if (n == 3) req1 = 1'b0;
        end

        // Randomized traffic from both requesters
        fork
            for (int k = 0; k < 10; k++) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                issue(0, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15)),
                      3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            end
            for (int k = 0; k < 10; k++) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                issue(1, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15)),
                      3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            end
        join
        repeat (4) @(negedge clk);
        chk("queues_drained", 64'(q0.size() + q1.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Two-port ALU operation sequencer that shares the `rom_alu` datapath between two requesters. It arbitrates round-robin and drives the B operand, then the A operand, onto the internal bus with the active-low `w_b`/`w_a` strobes. It then holds `runit`/`rollop` for a fixed settle time, captures `y` and the L toggle output, and returns the result with a one-cycle done pulse. It sits between the microcode/control layer and the ALU, replacing hand-sequenced operand loads.

## Interface
- `SETTLE`, default 2: cycles `runit` is held before `y` is captured; legal range 1..15.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: request; held high until matching `done`.
- `op0`, `op1` in 4: ALU unit code; legal only when bit 3 = 1 (1000 ADD … 1111 CS2).
- `roll0`, `roll1` in 3: roll sub-op, passed to `rollop`.
- `lin0`, `lin1` in 1: L flag input for the operation.
- `a0`, `b0`, `a1`, `b1` in 16: operands.
- `done0`, `done1` out 1: one-cycle completion pulse.
- `err` out 1: high with `done` when the op was illegal.
- `result` out 16: captured `y`; valid while `done` is high, held until next capture.
- `l_result` out 1: captured `alu_l_toggle`.
- `busy` out 1: high in every state except IDLE.
- `ibus_out` out 16, `ibus_drive` out 1: operand value and bus output enable.
- `w_a`, `w_b` out 1: active-low ALU A/B register write strobes.
- `runit` out 4, `rollop` out 3, `l_out` out 1: ALU control.
- `y` in 16, `alu_l_toggle` in 1: ALU result and carry/L-toggle.

## Operation
- States: IDLE, SETUP_B, STROBE_B, SETUP_A, STROBE_A, EXEC, DONE.
- IDLE: arbitrate. On grant, latch op, roll, lin, a and b, and record the winner. A legal op goes to SETUP_B. An illegal op (op[3]=0) goes straight to DONE with `err`=1, `result`=0 and `l_result`=0; no strobes are issued and `runit` stays 0.
- SETUP_B: `ibus_drive`=1, `ibus_out`=b, `w_b`=1.
- STROBE_B: same bus value, `w_b`=0.
- SETUP_A and STROBE_A: the same pair using a and `w_a`.
- EXEC: `ibus_drive`=0. `runit`=op, `rollop`=roll and `l_out`=lin, held for exactly SETTLE cycles using a 4-bit counter.
- Leaving EXEC: register `y` into `result` and `alu_l_toggle` into `l_result`, then go to DONE.
- DONE: `done<winner>`=1 for one cycle, `runit`/`rollop`/`l_out` return to 0, next state is IDLE.
- Arbitration is round-robin with a last-grant pointer; after reset the pointer favours requester 0. With both requests high, the requester not served last wins.
- A `req` dropped after grant does not abort the operation; `done` still pulses.
- Latched operands are used for the whole operation; input changes after grant are ignored.

## Timing
- Reset values (asynchronous, immediate):
  - `w_a`=`w_b`=1.
  - `ibus_drive`=0, `ibus_out`=0.
  - `runit`=0, `rollop`=0, `l_out`=0.
  - `done0`=`done1`=0, `err`=0, `busy`=0.
  - `result`=0, `l_result`=0, pointer=0.
  - State is IDLE.
- Reset mid-operation aborts it: no `done` is issued, and the requester must re-request.
- Grant at edge k moves the block through these states:
  - k+1: STROBE_B.
  - k+2: SETUP_A.
  - k+3: STROBE_A.
  - k+4: EXEC.
- Timing from edge k:
  - Capture happens at edge k+4+SETTLE.
  - `done` is high from edge k+4+SETTLE to edge k+5+SETTLE.
  - IDLE is reached at edge k+5+SETTLE.
  - The next grant is at edge k+6+SETTLE at the earliest.
- Back-to-back period is 6+SETTLE cycles (8 at default).
- Each strobe is low for exactly one cycle, with bus data stable one cycle before and throughout.
- Illegal op: grant at k, `done`/`err` high for the cycle after edge k.
- All outputs are registered; there is no combinational path from `req` or `y` to any output.

## Test plan
- **Single ADD:** `req0`, op=1000, a=0x1234, b=0x4321, SETTLE=2.
  - `ibus_out`=0x4321 while `w_b`=0 for exactly 1 cycle, then 0x1234 while `w_a`=0 for exactly 1 cycle.
  - `runit`=1000 for 2 cycles.
  - `done0` 6 cycles after grant, `result`=0x5555, `l_result`=0.
- **Carry:** a=0xFFFF, b=0x0001, ADD → `result`=0x0000, `l_result`=1.
- **Contention:** `req0` and `req1` held continuously from reset release → service order 0,1,0,1, with `done` pulses 8 cycles apart. Each `result` matches its own operands.
- **Illegal op:** op=0011 on `req1` → `done1`=1 and `err`=1 the cycle after grant. `w_a`/`w_b` never go low, `runit` stays 0000, `result`=0.
- **Reset during EXEC:** `runit`, `busy` and `ibus_drive` go to 0 immediately and no `done` is issued. After release, a new ADD 3+4 completes with `result`=7.
- **ROLL pass-through:** op=1100, `roll0`=010, `lin0`=1 → `rollop`=010 and `l_out`=1 for exactly SETTLE cycles. `req0` is dropped mid-operation and `done0` still pulses.
